// File: rtl/cm82_serial_add_ctrl.sv
// Serial adder controller: feeds an external combinational 2-bit adder slice
// two operand bits per cycle and assembles the WIDTH-bit sum and carry-out.
module cm82_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic             in_cin,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_c,
    output logic             slice_d,
    output logic             slice_e,
    input  logic             slice_f,
    input  logic             slice_g,
    input  logic             slice_h,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int STEPS = WIDTH / 2;
    localparam int K_W   = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [K_W-1:0]   k_r;
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] y_r;
    logic             last_step_s;

    assign last_step_s = (k_r == K_LAST);

    // Control FSM, operand shifters, sum/carry capture and registered slice drive.
    // Slice outputs are loaded one step ahead so they hold bit pair k during RUN step k;
    // out_cout doubles as the carry register and out_sum as the sum register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            k_r       <= {K_W{1'b0}};
            out_sum   <= {WIDTH{1'b0}};
            out_cout  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            slice_a   <= 1'b0;
            slice_b   <= 1'b0;
            slice_c   <= 1'b0;
            slice_d   <= 1'b0;
            slice_e   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        x_r      <= in_x >> 2'd2;
                        y_r      <= in_y >> 2'd2;
                        slice_a  <= in_cin;
                        slice_b  <= in_x[0];
                        slice_c  <= in_y[0];
                        slice_d  <= in_x[1];
                        slice_e  <= in_y[1];
                        out_cout <= in_cin;
                        out_sum  <= {WIDTH{1'b0}};
                        k_r      <= {K_W{1'b0}};
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state_r  <= RUN;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                RUN: begin
                    out_sum[{k_r, 1'b0}] <= slice_f;
                    out_sum[{k_r, 1'b1}] <= slice_g;
                    out_cout <= slice_h;
                    k_r      <= k_r + 1'b1;
                    if (last_step_s) begin
                        slice_a   <= 1'b0;
                        slice_b   <= 1'b0;
                        slice_c   <= 1'b0;
                        slice_d   <= 1'b0;
                        slice_e   <= 1'b0;
                        out_valid <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        slice_a <= slice_h;
                        slice_b <= x_r[0];
                        slice_c <= y_r[0];
                        slice_d <= x_r[1];
                        slice_e <= y_r[1];
                        x_r     <= x_r >> 2'd2;
                        y_r     <= y_r >> 2'd2;
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= IDLE;
                    end else begin
                        state_r   <= DONE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    slice_a   <= 1'b0;
                    slice_b   <= 1'b0;
                    slice_c   <= 1'b0;
                    slice_d   <= 1'b0;
                    slice_e   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cm82_serial_add_ctrl.sv
// Self-checking bench for cm82_serial_add_ctrl with a behavioural 2-bit adder slice.
module tb_cm82_serial_add_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_x;
    logic [W-1:0] in_y;
    logic         in_cin;
    logic         slice_a, slice_b, slice_c, slice_d, slice_e;
    logic         slice_f, slice_g, slice_h;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;
    logic [2:0]   slice_sum;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[8];

    cm82_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_cin(in_cin),
        .slice_a(slice_a), .slice_b(slice_b), .slice_c(slice_c),
        .slice_d(slice_d), .slice_e(slice_e),
        .slice_f(slice_f), .slice_g(slice_g), .slice_h(slice_h),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference 2-bit full adder slice.
    always_comb begin
        slice_sum = {2'b00, slice_a} + {1'b0, slice_d, slice_b} + {1'b0, slice_e, slice_c};
    end
    assign slice_f = slice_sum[0];
    assign slice_g = slice_sum[1];
    assign slice_h = slice_sum[2];

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transaction from IDLE, optionally stalling the result for hold cycles.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                          input logic [W-1:0] es, input logic ec, input int hold);
        int lat;
        logic [W-1:0] s0;
        in_valid = 1'b1; in_x = x; in_y = y; in_cin = c; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        lat = 1;
        chk("busy_run", {31'd0, busy}, 32'd1);
        chk("in_ready_run", {31'd0, in_ready}, 32'd0);
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("latency", lat, 32'd9);
        chk("sum", {16'd0, out_sum}, {16'd0, es});
        chk("cout", {31'd0, out_cout}, {31'd0, ec});
        s0 = out_sum;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_sum", {16'd0, out_sum}, {16'd0, s0});
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ret_in_ready", {31'd0, in_ready}, 32'd1);
        chk("ret_out_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_slices", {27'd0, slice_a, slice_b, slice_c, slice_d, slice_e}, 32'd0);
    endtask

    initial begin
        logic [W:0] r;
        logic [W:0] q[$];
        logic [W:0] e;
        int lat, nv, nres, last, acc;

        vecs[0] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[3] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[4] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[7] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_cin = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sum", {16'd0, out_sum}, 32'd0);
        chk("rst_cout", {31'd0, out_cout}, 32'd0);
        chk("rst_slices", {27'd0, slice_a, slice_b, slice_c, slice_d, slice_e}, 32'd0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            run_op(vecs[i].x, vecs[i].y, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout, 0);
        end

        // Stall the result for five cycles.
        run_op(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 5);

        // Reset in the middle of RUN at step 3.
        in_valid = 1'b1; in_x = 16'hFFFF; in_y = 16'h0001; in_cin = 1'b0;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_sum", {16'd0, out_sum}, 32'd0);
        chk("midrst_slices", {27'd0, slice_a, slice_b, slice_c, slice_d, slice_e}, 32'd0);
        nv = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) nv++;
        end
        chk("midrst_no_result", nv, 32'd0);
        run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 0);

        // Operand noise on in_valid during RUN and DONE.
        in_valid = 1'b1; in_x = 16'hA5A5; in_y = 16'h5A5A; in_cin = 1'b1;
        tick();
        lat = 1;
        while (!out_valid && lat < 40) begin
            in_valid = 1'($urandom_range(0, 1));
            in_x = 16'($urandom); in_y = 16'($urandom); in_cin = 1'($urandom_range(0, 1));
            tick();
            lat++;
            chk("noise_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        chk("noise_latency", lat, 32'd9);
        chk("noise_sum", {16'd0, out_sum}, 32'd0);
        chk("noise_cout", {31'd0, out_cout}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("noise_ret", {31'd0, in_ready}, 32'd1);

        // Random single transactions against the arithmetic model.
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] rx, ry;
            logic rc;
            rx = 16'($urandom); ry = 16'($urandom); rc = 1'($urandom_range(0, 1));
            r = ref_add(rx, ry, rc);
            run_op(rx, ry, rc, r[W-1:0], r[W], 0);
        end

        // Back-to-back with both handshakes tied high.
        in_valid = 1'b1; out_ready = 1'b1;
        nres = 0; last = -1;
        for (int cyc = 1; cyc <= 120; cyc++) begin
            in_x = 16'($urandom); in_y = 16'($urandom); in_cin = 1'($urandom_range(0, 1));
            acc = int'(in_ready);
            r = ref_add(in_x, in_y, in_cin);
            tick();
            if (acc != 0) q.push_back(r);
            if (out_valid) begin
                if (q.size() > 0) e = q.pop_front();
                else e = '1;
                chk("b2b_sum", {16'd0, out_sum}, {16'd0, e[W-1:0]});
                chk("b2b_cout", {31'd0, out_cout}, {31'd0, e[W]});
                if (last >= 0) chk("b2b_interval", cyc - last, 32'd10);
                last = cyc;
                nres++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_count_ok", {31'd0, (nres >= 11)}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cm82_serial_add_ctrl.md
CM82_SERIAL_ADD_CTRL -- requirements
Module: cm82_serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be even and >= 2.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operand pair offered.
REQ-005 in_ready  output  1  controller can accept an operand pair.
REQ-006 in_x  input  WIDTH  first operand.
REQ-007 in_y  input  WIDTH  second operand.
REQ-008 in_cin  input  1  carry-in.
REQ-009 slice_a  output  1  carry into the external 2-bit adder slice.
REQ-010 slice_b, slice_c  output  1 each  bit-0 operands of the slice.
REQ-011 slice_d, slice_e  output  1 each  bit-1 operands of the slice.
REQ-012 slice_f, slice_g, slice_h  input  1 each  slice sum bit 0, sum bit 1 and carry-out.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  consumer accepts the result.
REQ-015 out_sum  output  WIDTH  sum result.
REQ-016 out_cout  output  1  final carry-out.
REQ-017 busy  output  1  high in RUN and DONE.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-019 in_ready SHALL be high only in IDLE; out_valid SHALL be high only in DONE.
REQ-020 IDLE with in_valid=1 at edge T: latch in_x and in_y, set carry register to in_cin, clear step index k and sum register, and enter RUN at T+1; in_valid=0 keeps IDLE.
REQ-021 In RUN, step k SHALL drive slice_a=carry, slice_b=x[2k], slice_c=y[2k], slice_d=x[2k+1], slice_e=y[2k+1].
REQ-022 Each RUN cycle SHALL capture sum[2k]<=slice_f, sum[2k+1]<=slice_g, carry<=slice_h, and k<=k+1; the slice is purely combinational, with the result used the same cycle.
REQ-023 RUN SHALL last exactly WIDTH/2 cycles; after the step with k=WIDTH/2-1 the FSM SHALL enter DONE.
REQ-024 Latency: with acceptance at edge T, out_valid SHALL first be high in the cycle after edge T+WIDTH/2 (16 -> 8 RUN cycles, then out_valid).
REQ-025 out_sum and out_cout SHALL reflect the sum and carry registers, and SHALL be stable while out_valid=1 and out_ready=0.
REQ-026 DONE with out_ready=1 at an edge SHALL return to IDLE; out_ready=1 on entering DONE gives a single-cycle out_valid.
REQ-027 Overlap: a new operand SHALL NOT be accepted in the same cycle as result handshake, since in_ready=0 in DONE, giving minimum initiation interval WIDTH/2+2 cycles.
REQ-028 in_valid while busy SHALL be ignored, with no state or register change.
REQ-029 slice_a..slice_e SHALL be 0 outside RUN.
REQ-030 Width wrap: out_sum SHALL be (in_x+in_y+in_cin) mod 2^WIDTH, and out_cout SHALL be bit WIDTH of that sum.
REQ-031 out_ready in IDLE or RUN SHALL have no effect.

Reset
REQ-032 rst=1 at an edge SHALL force IDLE, k=0, carry=0, sum=0, out_valid=0, busy=0 and slice_a..slice_e=0, and set in_ready=1 the following cycle.
REQ-033 rst SHALL take priority over every handshake; rst mid-RUN or in DONE SHALL discard the operation and produce no out_valid.
REQ-034 Only control state and the sum/carry registers need reset; operand registers may be left unreset.

Verification (WIDTH=16, slice = reference 2-bit full adder model)
REQ-035 0x0001+0x0001, cin=0 -> out_sum=0x0002, out_cout=0, with out_valid 9 cycles after acceptance.
REQ-036 0xFFFF+0x0001, cin=0 -> out_sum=0x0000, out_cout=1; 0xFFFF+0xFFFF, cin=1 -> out_sum=0xFFFF, out_cout=1.
REQ-037 out_ready held 0 for 5 cycles in DONE -> out_valid and out_sum stay constant, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-038 rst pulsed at RUN step k=3 -> IDLE next cycle, no out_valid; then 0x1234+0x4321 -> 0x5555, cout=0.
REQ-039 in_valid toggled with new operands throughout RUN -> result unaffected (0xA5A5+0x5A5A, cin=1 -> 0x0000, cout=1).
REQ-040 Back-to-back transfers with in_valid and out_ready tied high -> one result every 10 cycles, all matching the reference sum.
